ahb3lite_interconnect_slave_arbiter: RTL
========================================

Name: ahb3lite_interconnect_slave_arbiter

Overview:
Per-slave-port arbiter for the AHB3-Lite multi-layer switch. It collects the slave-select requests from all master ports aimed at one slave and grants that slave to one master, using priority first and round-robin among equal priorities. Ownership changes only at transfer/burst boundaries signalled by each master port's can_switch. It also drives the address-phase and data-phase mux selects for the slave-side datapath.

Parameters:
- MASTERS, 3: number of master ports competing for this slave.
- MASTER_BITS, (MASTERS>1 ? $clog2(MASTERS) : 1): index/priority width (localparam role).
- STARVE_BITS, 4: wait-counter width (used only with the optional feature).

Ports:
- HCLK  in  1  clock, rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- mst_HSEL  in  MASTERS  request per master port (that port's slvHSEL bit for this slave).
- mst_priority  in  MASTERS x MASTER_BITS  per-master priority; larger value is higher priority.
- can_switch  in  MASTERS  per-master "may release slave next cycle".
- slv_HREADY  in  1  slave HREADYOUT; address phase accepted when high.
- master_granted  out  MASTERS  one-hot registered grant (current owner).
- granted_master  out  MASTER_BITS  index of owner; address-phase mux select.
- data_master  out  MASTER_BITS  index of the master owning the current data phase; selects HWDATA and routes HREADY/HRESP.
- data_active  out  1  a non-idle data phase is in progress for data_master.

Behaviour:
- Reset (async, HRESET=1): master_granted='b1 (parked on master 0), granted_master=0, data_master=0, data_active=0, rr_ptr=0, state=IDLE.
- State machine: IDLE (no owner transfer in flight, grant parked) and OWNED (owner has an open transfer or burst).
- Winner, combinational: among mst_HSEL set bits, take the maximum mst_priority. Break ties by the first index found scanning upward from rr_ptr+1 modulo MASTERS.
- Switch condition: slv_HREADY & (IDLE | can_switch[owner]) & |mst_HSEL.
  - When true, the grant moves to the winner at the next edge. rr_ptr<=winner.
  - If the winner equals the owner, the grant is unchanged and rr_ptr is still updated.
- No requests: grant stays parked on the last owner (no change). State goes to IDLE when slv_HREADY & ~mst_HSEL[owner].
- IDLE->OWNED: when mst_HSEL[owner_next] & slv_HREADY.
- OWNED->IDLE: when slv_HREADY & can_switch[owner] & ~|mst_HSEL.
- OWNED with can_switch[owner]=0: the grant is held regardless of higher-priority requests. This covers locked sequences and bursts; the arbiter does not decode HMASTLOCK itself.
- slv_HREADY=0: grant, rr_ptr, data_master and data_active are all frozen.
- Data phase: on slv_HREADY=1, data_master<=granted_master and data_active<=mst_HSEL[granted_master].
- Latency: the parked owner gets access in 0 cycles. A new master gets its grant on the edge after the switch condition, so the master port sees 1 pending cycle.
- Grant is one-hot at all times. A single requester with MASTERS=1 is permanently granted.
- Reset asserted mid-burst: immediate return to reset values; no partial state is retained.

Optional Feature:
Macro AHB3LITE_ARB_STARVE_EN.
- With the macro:
  - Each master has a STARVE_BITS saturating counter. It increments while mst_HSEL=1 and the master is not owner, at edges where a switch was allowed but another master won.
  - The counter clears on grant or when the request drops.
  - A master whose counter is all-ones is "starving" and beats every non-starving master regardless of priority. Multiple starving masters are resolved round-robin.
- Without the macro: pure priority plus round-robin; no counters are synthesised.

Decomposition:
- Package ahb3lite_pkg (existing): HTRANS/HBURST constants. Add arbiter state enum type ARB_IDLE/ARB_OWNED.
- One natural sub-module: ahb3lite_interconnect_rr_picker. It is combinational, takes request vector, priorities, rr_ptr and an optional starving vector, and returns the winner index plus a valid flag.

Test Plan:
- Reset then single master 1 request, slv_HREADY=1 -> master_granted goes 'b001->'b010 one edge later; data_master=1 and data_active=1 the following edge.
- Masters 0 and 2, both priority 1, continuous requests, can_switch=1 -> grants alternate 0,2,0,2 each switch.
- Master 0 (prio 0) owns with can_switch=0 for 4 cycles, master 1 (prio 2) requests -> grant held for 4 cycles, moves to master 1 the edge after can_switch[0]=1.
- slv_HREADY=0 for 3 cycles during a switch request -> master_granted and data_master unchanged until slv_HREADY=1.
- HRESET pulse while master 2 owns mid-burst -> outputs immediately 'b001/0/0/0.
- With AHB3LITE_ARB_STARVE_EN and STARVE_BITS=2: master 0 (prio 0) loses 3 arbitrations to master 1 (prio 3) -> granted on the 4th switch. Without the macro, master 0 is never granted.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite constants and the slave-port arbiter state type.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ahb3lite_interconnect_slave_arbiter_if.sv
// Request/grant bundle between the master-port side of the switch and one slave arbiter.
interface ahb3lite_interconnect_slave_arbiter_if #(
  parameter int MASTERS = 3
);
  localparam int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  logic [MASTERS-1:0]                  mst_HSEL;
  logic [MASTERS-1:0][MASTER_BITS-1:0] mst_priority;
  logic [MASTERS-1:0]                  can_switch;
  logic                                slv_HREADY;
  logic [MASTERS-1:0]                  master_granted;
  logic [MASTER_BITS-1:0]              granted_master;
  logic [MASTER_BITS-1:0]              data_master;
  logic                                data_active;

  modport master (
    output mst_HSEL, mst_priority, can_switch, slv_HREADY,
    input  master_granted, granted_master, data_master, data_active
  );

  modport slave (
    input  mst_HSEL, mst_priority, can_switch, slv_HREADY,
    output master_granted, granted_master, data_master, data_active
  );

endinterface

// File: rtl/ahb3lite_interconnect_rr_picker.sv
// Combinational winner select: highest key wins, ties go to the first index after rr_ptr.
module ahb3lite_interconnect_rr_picker #(
  parameter int MASTERS     = 3,
  parameter int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic [MASTERS-1:0]                  req,
  input  logic [MASTERS-1:0][MASTER_BITS-1:0] prio,
  input  logic [MASTER_BITS-1:0]              rr_ptr,
  input  logic [MASTERS-1:0]                  starving,
  output logic [MASTER_BITS-1:0]              winner,
  output logic                                valid
);

  always_comb begin
    logic [MASTER_BITS:0] best_key;
    logic [MASTER_BITS:0] key;
    int                   idx;
    winner   = '0;
    valid    = 1'b0;
    best_key = '0;
    key      = '0;
    idx      = 0;
    // Starving masters share one key so they rotate among themselves, ignoring priority.
    for (int k = 1; k <= MASTERS; k++) begin
      idx = (int'(rr_ptr) + k) % MASTERS;
      key = starving[idx] ? {1'b1, {MASTER_BITS{1'b0}}} : {1'b0, prio[idx]};
      if (req[idx] && (!valid || key > best_key)) begin
        valid    = 1'b1;
        best_key = key;
        winner   = MASTER_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave arbiter: priority + round-robin grant, switching only at can_switch boundaries.
// Optional starvation counters enabled by defining AHB3LITE_ARB_STARVE_EN.
module ahb3lite_interconnect_slave_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int MASTERS     = 3,
  parameter int STARVE_BITS = 4
) (
  input  logic HCLK,
  input  logic HRESET,
  ahb3lite_interconnect_slave_arbiter_if.slave bus
);

  localparam int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  arb_state_t             state_q, state_d;
  logic [MASTERS-1:0]     grant_q, grant_d;
  logic [MASTER_BITS-1:0] owner_q, owner_d;
  logic [MASTER_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [MASTER_BITS-1:0] data_master_q, data_master_d;
  logic                   data_active_q, data_active_d;
  logic [MASTER_BITS-1:0] winner;
  logic                   win_valid;
  logic [MASTERS-1:0]     starving;
  logic                   switch_ok;

  ahb3lite_interconnect_rr_picker #(
    .MASTERS    (MASTERS),
    .MASTER_BITS(MASTER_BITS)
  ) u_picker (
    .req     (bus.mst_HSEL),
    .prio    (bus.mst_priority),
    .rr_ptr  (rr_ptr_q),
    .starving(starving),
    .winner  (winner),
    .valid   (win_valid)
  );

  assign switch_ok = bus.slv_HREADY && win_valid &&
                     ((state_q == ARB_IDLE) || bus.can_switch[owner_q]);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    data_master_d = data_master_q;
    data_active_d = data_active_q;
    if (switch_ok) begin
      owner_d  = winner;
      grant_d  = MASTERS'(1) << winner;
      rr_ptr_d = winner;
    end
    // With HREADY low everything freezes, including the data-phase owner.
    if (bus.slv_HREADY) begin
      state_d       = bus.mst_HSEL[owner_d] ? ARB_OWNED : ARB_IDLE;
      data_master_d = owner_q;
      data_active_d = bus.mst_HSEL[owner_q];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q       <= ARB_IDLE;
      grant_q       <= MASTERS'(1);
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      data_master_q <= '0;
      data_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      data_master_q <= data_master_d;
      data_active_q <= data_active_d;
    end
  end

`ifdef AHB3LITE_ARB_STARVE_EN
  logic [MASTERS-1:0][STARVE_BITS-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    starving     = '0;
    for (int i = 0; i < MASTERS; i++) begin
      starving[i] = &starve_cnt_q[i];
      if (!bus.mst_HSEL[i] || (switch_ok && winner == MASTER_BITS'(i))) begin
        starve_cnt_d[i] = '0;
      end else if (switch_ok && owner_q != MASTER_BITS'(i) && !starving[i]) begin
        starve_cnt_d[i] = starve_cnt_q[i] + STARVE_BITS'(1);
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starving = '0;
`endif

  assign bus.master_granted = grant_q;
  assign bus.granted_master = owner_q;
  assign bus.data_master    = data_master_q;
  assign bus.data_active    = data_active_q;

endmodule
